mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage, directly downstream of the EXE→MEM pipeline register.
- Consumes the registered mem_* fields and runs a req/addr_ok/data_ok transaction on the data SRAM for loads and stores.
- Aligns and extends load data, and registers the result into the MEM→WB boundary.
- Drives mem_ready_go back upstream to stall the pipeline while a transaction is outstanding.

Parameters:
- ALE_CHECK, 1, when 1 a misaligned access suppresses the SRAM request and raises wb_ale; when 0 address bits below the access size are ignored.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_valid  in  1  MEM-stage slot holds a live instruction.
- mem_op  in  3  encoding: 0 LD_B, 1 LD_H, 2 LD_W, 3 LD_BU, 4 LD_HU, 5 ST_B, 6 ST_H, 7 ST_W.
- mem_dram_re  in  1  instruction is a load.
- mem_dram_we  in  1  instruction is a store.
- mem_res_from_dram  in  1  writeback value comes from load data rather than the ALU.
- mem_ref_we  in  1  register-file write enable.
- mem_rd  in  5  destination register.
- mem_alu_result  in  32  ALU result, or load address.
- mem_dram_waddr  in  32  store address.
- mem_dram_wdata  in  32  raw store data.
- mem_pc  in  32  instruction PC.
- wb_allow_in  in  1  WB stage can accept an instruction this cycle.
- mem_ready_go  out  1  MEM has finished its work for the current instruction.
- data_sram_req  out  1  request valid.
- data_sram_wr  out  1  1 = write.
- data_sram_size  out  2  0 = byte, 1 = half, 2 = word.
- data_sram_wstrb  out  4  byte-lane write strobes.
- data_sram_addr  out  32  access address.
- data_sram_wdata  out  32  lane-replicated store data.
- data_sram_addr_ok  in  1  request accepted.
- data_sram_data_ok  in  1  response returned.
- data_sram_rdata  in  32  read data.
- mem_fwd_valid  out  1  MEM holds a pending register write.
- mem_fwd_ready  out  1  mem_fwd_data is final.
- mem_fwd_rd  out  5  destination register being forwarded.
- mem_fwd_data  out  32  forwarded value.
- wb_valid  out  1  WB register holds a live instruction.
- wb_ref_we  out  1  registered write enable.
- wb_rd  out  5  registered destination.
- wb_result  out  32  registered writeback value.
- wb_pc  out  32  registered PC.
- wb_ale  out  1  registered misaligned-access flag.

Behaviour:
- Access = mem_valid & (dram_re | dram_we). Address = dram_we ? mem_dram_waddr : mem_alu_result.
- Misaligned (ALE_CHECK=1): half with addr[0]≠0, or word with addr[1:0]≠0. No request is issued and mem_ready_go = 1 immediately.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE → REQ on an aligned access. Address, size, wstrb and wdata are latched into internal registers.
  - REQ: data_sram_req = 1, driven from the latched copies and held stable until addr_ok.
    - addr_ok & data_ok in the same cycle → DONE.
    - addr_ok alone → WAIT.
  - WAIT: data_ok → DONE; rdata is captured, aligned and extended into the load result register.
  - DONE: mem_ready_go = 1. DONE → IDLE when wb_allow_in = 1.
- data_ok arriving in IDLE or DONE is ignored.
- Request length: at most one request per instruction; req is never reasserted before DONE.
- mem_ready_go:
  - = mem_valid for non-access instructions and for misaligned accesses.
  - = (state == DONE) for aligned accesses.
  - Always 0 in REQ and WAIT.
- Store encoding:
  - byte: wdata = {4{b}}, wstrb = 0001 << addr[1:0].
  - half: wdata = {2{h}}, wstrb = 0011 << {addr[1],1'b0}.
  - word: wdata passed through, wstrb = 1111.
  - Loads drive wstrb = 0000.
- Load extraction: shift rdata right by addr[1:0]×8, then sign-extend (LD_B, LD_H) or zero-extend (LD_BU, LD_HU).
- Writeback result = mem_res_from_dram ? load result : mem_alu_result.
- WB register:
  - On mem_valid & mem_ready_go & wb_allow_in: wb_* ← current instruction, wb_valid ← 1, wb_ref_we ← ref_we & ~ale.
  - Else if wb_allow_in: wb_valid ← 0.
  - Otherwise all wb_* fields hold.
- Forwarding:
  - mem_fwd_valid = mem_valid & mem_ref_we & (mem_rd ≠ 0).
  - mem_fwd_ready = ~mem_res_from_dram | (state == DONE).
  - mem_fwd_data = writeback result.
- Reset, including mid-transaction: state → IDLE; req, wr, wstrb, size, addr, wdata = 0; all wb_* = 0; internal latches = 0. Any data_ok that follows reset is discarded.

Decomposition:
- Shared package holds:
  - mem_op encoding constants: MEM_OP_LD_B … MEM_OP_ST_W.
  - FSM state constants: MS_IDLE, MS_REQ, MS_WAIT, MS_DONE.
  - SRAM size codes: SZ_B, SZ_H, SZ_W.
- One sub-module, mem_align: purely combinational. Produces store lane replication and wstrb, load shift/extension, and the misalignment check.

Test Plan:
- ALU op: mem_valid=1, dram_re=we=0, alu_result=0x1234, wb_allow_in=1 → mem_ready_go=1 same cycle; next cycle wb_valid=1, wb_result=0x1234, no data_sram_req.
- LD_B at addr 0x…03, rdata=0x80FF_0011, addr_ok held 2 cycles, data_ok 3 cycles later → req high exactly until addr_ok; wb_result=0xFFFF_FF80; mem_ready_go low throughout REQ/WAIT.
- ST_H at addr 0x…02, wdata=0xABCD → wr=1, size=1, wstrb=1100, wdata=0xABCD_ABCD; addr_ok & data_ok same cycle → DONE next cycle.
- LD_W at addr 0x…01 with ALE_CHECK=1 → no req, wb_ale=1, wb_ref_we=0.
- Load completes while wb_allow_in=0 for 3 cycles → FSM stays in DONE, mem_fwd_ready=1, wb_* unchanged; advances once wb_allow_in=1.
- rst asserted while in WAIT, then a stray data_ok → req=0 asynchronously, state IDLE, stray data_ok ignored, wb_valid=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the mem_op encoding, the SRAM size codes, the FSM state type,
// the request payload struct and small op-decoding helpers.
package mem_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned SIZE_W  = 2;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned REG_W   = 5;

    // mem_op encoding
    localparam logic [OP_W-1:0] MEM_OP_LD_B  = 3'd0;
    localparam logic [OP_W-1:0] MEM_OP_LD_H  = 3'd1;
    localparam logic [OP_W-1:0] MEM_OP_LD_W  = 3'd2;
    localparam logic [OP_W-1:0] MEM_OP_LD_BU = 3'd3;
    localparam logic [OP_W-1:0] MEM_OP_LD_HU = 3'd4;
    localparam logic [OP_W-1:0] MEM_OP_ST_B  = 3'd5;
    localparam logic [OP_W-1:0] MEM_OP_ST_H  = 3'd6;
    localparam logic [OP_W-1:0] MEM_OP_ST_W  = 3'd7;

    // data_sram_size codes
    localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2,
        MS_DONE = 2'd3
    } ms_state_t;

    // Request fields held stable toward the SRAM for the life of a transaction
    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
    } sram_req_t;

    // Access width of an op
    function automatic logic [SIZE_W-1:0] op_size(input logic [OP_W-1:0] op);
        logic [SIZE_W-1:0] sz;
        case (op)
            MEM_OP_LD_B, MEM_OP_LD_BU, MEM_OP_ST_B: sz = SZ_B;
            MEM_OP_LD_H, MEM_OP_LD_HU, MEM_OP_ST_H: sz = SZ_H;
            default:                                sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data-path helpers for mem_stage.
// Ports:
//   i_op, i_is_store, i_addr, i_st_data : current instruction (request side)
//   i_ld_op, i_ld_off, i_rdata          : latched load op/offset and SRAM read data
//   o_size_c, o_addr_c                  : access size and effective address
//   o_wstrb_c, o_wdata_c                : byte strobes and lane-replicated store data
//   o_misaligned_c                      : access not naturally aligned (ALE_CHECK only)
//   o_ld_data_c                         : aligned and extended load value
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned ALE_CHECK = 1
)
(
    input  logic [OP_W-1:0]   i_op,
    input  logic              i_is_store,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_st_data,
    input  logic [OP_W-1:0]   i_ld_op,
    input  logic [1:0]        i_ld_off,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [SIZE_W-1:0] o_size_c,
    output logic [XLEN-1:0]   o_addr_c,
    output logic [STRB_W-1:0] o_wstrb_c,
    output logic [XLEN-1:0]   o_wdata_c,
    output logic              o_misaligned_c,
    output logic [XLEN-1:0]   o_ld_data_c
);

    logic [SIZE_W-1:0] w_size;
    logic              w_low_bad;
    logic [XLEN-1:0]   w_addr_eff;
    logic [XLEN-1:0]   w_shifted;

    // Size, alignment check and effective address (low bits dropped when not checked)
    always_comb begin
        w_size     = op_size(i_op);
        w_low_bad  = 1'b0;
        w_addr_eff = i_addr;
        case (w_size)
            SZ_H: begin
                w_low_bad     = i_addr[0];
                w_addr_eff[0] = 1'b0;
            end
            SZ_W: begin
                w_low_bad       = |i_addr[1:0];
                w_addr_eff[1:0] = 2'b00;
            end
            default: ;
        endcase
        o_size_c       = w_size;
        o_addr_c       = w_addr_eff;
        o_misaligned_c = (ALE_CHECK != 0) && w_low_bad;
    end

    // Store lane replication and strobes; loads never strobe
    always_comb begin
        o_wdata_c = i_st_data;
        o_wstrb_c = 4'b1111;
        case (w_size)
            SZ_B: begin
                o_wdata_c = {4{i_st_data[7:0]}};
                o_wstrb_c = 4'b0001 << w_addr_eff[1:0];
            end
            SZ_H: begin
                o_wdata_c = {2{i_st_data[15:0]}};
                o_wstrb_c = 4'b0011 << {w_addr_eff[1], 1'b0};
            end
            default: ;
        endcase
        if (!i_is_store) begin
            o_wstrb_c = 4'b0000;
        end
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend
    always_comb begin
        w_shifted   = i_rdata >> {i_ld_off, 3'b000};
        o_ld_data_c = w_shifted;
        case (i_ld_op)
            MEM_OP_LD_B:  o_ld_data_c = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_OP_LD_BU: o_ld_data_c = {24'd0, w_shifted[7:0]};
            MEM_OP_LD_H:  o_ld_data_c = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_OP_LD_HU: o_ld_data_c = {16'd0, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage.
// Takes the registered EXE->MEM fields, runs one req/addr_ok/data_ok
// transaction on the data SRAM per load/store, aligns load data and
// registers the result into the MEM->WB boundary.
// Ports:
//   mem_*              : instruction currently in MEM (from EXE->MEM register)
//   wb_allow_in        : WB can accept this cycle
//   mem_ready_go       : MEM is finished with the current instruction
//   data_sram_*        : SRAM request/response channel
//   mem_fwd_*          : forwarding of the pending register write
//   wb_*               : registered MEM->WB payload
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ALE_CHECK = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [OP_W-1:0]   mem_op,
    input  logic              mem_dram_re,
    input  logic              mem_dram_we,
    input  logic              mem_res_from_dram,
    input  logic              mem_ref_we,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [XLEN-1:0]   mem_alu_result,
    input  logic [XLEN-1:0]   mem_dram_waddr,
    input  logic [XLEN-1:0]   mem_dram_wdata,
    input  logic [XLEN-1:0]   mem_pc,
    input  logic              wb_allow_in,
    output logic              mem_ready_go,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [SIZE_W-1:0] data_sram_size,
    output logic [STRB_W-1:0] data_sram_wstrb,
    output logic [XLEN-1:0]   data_sram_addr,
    output logic [XLEN-1:0]   data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [XLEN-1:0]   data_sram_rdata,
    output logic              mem_fwd_valid,
    output logic              mem_fwd_ready,
    output logic [REG_W-1:0]  mem_fwd_rd,
    output logic [XLEN-1:0]   mem_fwd_data,
    output logic              wb_valid,
    output logic              wb_ref_we,
    output logic [REG_W-1:0]  wb_rd,
    output logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   wb_pc,
    output logic              wb_ale
);

    ms_state_t         r_state;
    ms_state_t         w_next_state;
    logic              r_req;
    sram_req_t         r_sram;
    sram_req_t         w_sram;
    logic [OP_W-1:0]   r_op;
    logic [XLEN-1:0]   r_load_result;

    logic              w_access;
    logic              w_misaligned;
    logic              w_ale;
    logic              w_start;
    logic              w_capture;
    logic              w_wb_load;
    logic [XLEN-1:0]   w_addr;
    logic [XLEN-1:0]   w_result;
    logic [SIZE_W-1:0] w_size;
    logic [XLEN-1:0]   w_addr_eff;
    logic [STRB_W-1:0] w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ld_data;

    assign w_access = mem_valid & (mem_dram_re | mem_dram_we);
    assign w_addr   = mem_dram_we ? mem_dram_waddr : mem_alu_result;
    assign w_ale    = w_access & w_misaligned;
    assign w_start  = w_access & ~w_misaligned;

    mem_align #(
        .ALE_CHECK (ALE_CHECK)
    ) u_align (
        .i_op           (mem_op),
        .i_is_store     (mem_dram_we),
        .i_addr         (w_addr),
        .i_st_data      (mem_dram_wdata),
        .i_ld_op        (r_op),
        .i_ld_off       (r_sram.addr[1:0]),
        .i_rdata        (data_sram_rdata),
        .o_size_c       (w_size),
        .o_addr_c       (w_addr_eff),
        .o_wstrb_c      (w_wstrb),
        .o_wdata_c      (w_wdata),
        .o_misaligned_c (w_misaligned),
        .o_ld_data_c    (w_ld_data)
    );

    // Request payload to latch when a transaction starts
    always_comb begin
        w_sram       = '0;
        w_sram.wr    = mem_dram_we;
        w_sram.size  = w_size;
        w_sram.wstrb = w_wstrb;
        w_sram.addr  = w_addr_eff;
        w_sram.wdata = w_wdata;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state, stage handshake and load-capture strobe
    always_comb begin
        w_next_state = r_state;
        mem_ready_go = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            MS_IDLE: begin
                if (w_start) begin
                    w_next_state = MS_REQ;
                end else begin
                    // non-access or misaligned: nothing to wait for
                    mem_ready_go = mem_valid;
                end
            end
            MS_REQ: begin
                if (data_sram_addr_ok) begin
                    if (data_sram_data_ok) begin
                        w_next_state = MS_DONE;
                        w_capture    = 1'b1;
                    end else begin
                        w_next_state = MS_WAIT;
                    end
                end
            end
            MS_WAIT: begin
                if (data_sram_data_ok) begin
                    w_next_state = MS_DONE;
                    w_capture    = 1'b1;
                end
            end
            MS_DONE: begin
                mem_ready_go = 1'b1;
                if (wb_allow_in) begin
                    w_next_state = MS_IDLE;
                end
            end
            default: w_next_state = MS_IDLE;
        endcase
    end

    // Request latches; req drops on acceptance and is only raised from IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_sram <= '0;
            r_op   <= '0;
        end else if ((r_state == MS_IDLE) && w_start) begin
            r_req  <= 1'b1;
            r_sram <= w_sram;
            r_op   <= mem_op;
        end else if ((r_state == MS_REQ) && data_sram_addr_ok) begin
            r_req  <= 1'b0;
        end
    end

    // Load result register; only written on the accepted response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_result <= '0;
        end else if (w_capture) begin
            r_load_result <= w_ld_data;
        end
    end

    assign data_sram_req   = r_req;
    assign data_sram_wr    = r_sram.wr;
    assign data_sram_size  = r_sram.size;
    assign data_sram_wstrb = r_sram.wstrb;
    assign data_sram_addr  = r_sram.addr;
    assign data_sram_wdata = r_sram.wdata;

    assign w_result  = mem_res_from_dram ? r_load_result : mem_alu_result;
    assign w_wb_load = mem_valid & mem_ready_go & wb_allow_in;

    // Forwarding of the pending write; load values are final only in DONE
    assign mem_fwd_valid = mem_valid & mem_ref_we & (mem_rd != 5'd0);
    assign mem_fwd_ready = ~mem_res_from_dram | (r_state == MS_DONE);
    assign mem_fwd_rd    = mem_rd;
    assign mem_fwd_data  = w_result;

    // MEM->WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_ref_we <= 1'b0;
            wb_rd     <= '0;
            wb_result <= '0;
            wb_pc     <= '0;
            wb_ale    <= 1'b0;
        end else if (w_wb_load) begin
            wb_valid  <= 1'b1;
            wb_ref_we <= mem_ref_we & ~w_ale;
            wb_rd     <= mem_rd;
            wb_result <= w_result;
            wb_pc     <= mem_pc;
            wb_ale    <= w_ale;
        end else if (wb_allow_in) begin
            wb_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_dram_re, mem_dram_we, mem_res_from_dram, mem_ref_we;
    logic [2:0]  mem_op;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result, mem_dram_waddr, mem_dram_wdata, mem_pc;
    logic        wb_allow_in;
    logic        mem_ready_go;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_fwd_valid, mem_fwd_ready;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_valid, wb_ref_we, wb_ale;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result, wb_pc;

    int n_checks = 0;
    int n_errors = 0;

    // Reference view of the last instruction retired into WB
    logic [31:0] m_wb_result;
    logic        m_res_known;

    always #5 clk = ~clk;

    mem_stage #(.ALE_CHECK(1)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_op(mem_op), .mem_dram_re(mem_dram_re),
        .mem_dram_we(mem_dram_we), .mem_res_from_dram(mem_res_from_dram),
        .mem_ref_we(mem_ref_we), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
        .mem_dram_waddr(mem_dram_waddr), .mem_dram_wdata(mem_dram_wdata), .mem_pc(mem_pc),
        .wb_allow_in(wb_allow_in), .mem_ready_go(mem_ready_go),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_ready(mem_fwd_ready),
        .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_valid(wb_valid), .wb_ref_we(wb_ref_we), .wb_rd(wb_rd),
        .wb_result(wb_result), .wb_pc(wb_pc), .wb_ale(wb_ale)
    );

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int op_bytes(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd3 || op == 3'd5) return 1;
        if (op == 3'd1 || op == 3'd4 || op == 3'd6) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint unsigned v, span;
        int nb;
        nb   = op_bytes(op);
        span = 64'd1 << (8 * nb);
        v    = (64'(rdata) >> (8 * int'(addr % 4))) % span;
        if ((op == 3'd0 || op == 3'd1) && v >= span / 2) v = v + (64'h1_0000_0000 - span);
        return 32'(v);
    endfunction

    function automatic logic [31:0] exp_wdata(input int nb, input logic [31:0] d);
        logic [31:0] lo8, lo16;
        lo8  = d % 256;
        lo16 = d % 65536;
        if (nb == 1) return lo8 * 32'h0101_0101;
        if (nb == 2) return lo16 * 32'h0001_0001;
        return d;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        mem_valid = 0; mem_op = 0; mem_dram_re = 0; mem_dram_we = 0;
        mem_res_from_dram = 0; mem_ref_we = 0; mem_rd = 0;
        mem_alu_result = 0; mem_dram_waddr = 0; mem_dram_wdata = 0; mem_pc = 0;
        wb_allow_in = 1; data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    endtask

    task automatic run_alu(input logic [31:0] alu, input logic [4:0] rd, input logic ref_we,
                           input logic [31:0] pc);
        @(negedge clk);
        drive_idle();
        mem_valid = 1; mem_alu_result = alu; mem_rd = rd; mem_ref_we = ref_we; mem_pc = pc;
        #1;
        n_checks++;
        if ({mem_ready_go, data_sram_req, mem_fwd_valid, mem_fwd_ready, mem_fwd_data} !==
            {1'b1, 1'b0, (ref_we && rd != 0), 1'b1, alu}) begin
            n_errors++;
            $display("FAIL alu_comb got rg=%b req=%b fv=%b fr=%b fd=%h want rg=1 req=0 fv=%b fr=1 fd=%h",
                     mem_ready_go, data_sram_req, mem_fwd_valid, mem_fwd_ready, mem_fwd_data,
                     (ref_we && rd != 0), alu);
        end
        @(negedge clk);
        n_checks++;
        if ({wb_valid, wb_ref_we, wb_rd, wb_result, wb_pc, wb_ale, data_sram_req} !==
            {1'b1, ref_we, rd, alu, pc, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL alu_wb got v=%b we=%b rd=%0d res=%h pc=%h ale=%b req=%b want 1 %b %0d %h %h 0 0",
                     wb_valid, wb_ref_we, wb_rd, wb_result, wb_pc, wb_ale, data_sram_req,
                     ref_we, rd, alu, pc);
        end
        m_wb_result = alu; m_res_known = 1;
        mem_valid = 0;
    endtask

    // One load/store through the stage with a responding SRAM and optional WB stall
    task automatic run_access(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] other, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int ao_dly, input int do_dly,
                              input int stall, input logic ref_we, input logic [4:0] rd,
                              input logic [31:0] pc);
        bit is_st, ale, accepted, responded;
        int nb, req_cyc, wait_left, guard;
        logic [31:0] alu, exp_res;
        is_st = (op >= 3'd5);
        nb    = op_bytes(op);
        ale   = (addr % nb) != 0;
        alu   = is_st ? other : addr;
        exp_res = is_st ? alu : exp_load(op, addr, rdata);
        @(negedge clk);
        drive_idle();
        mem_valid = 1; mem_op = op; mem_dram_re = !is_st; mem_dram_we = is_st;
        mem_res_from_dram = !is_st; mem_ref_we = ref_we; mem_rd = rd;
        mem_alu_result = alu; mem_dram_waddr = is_st ? addr : other;
        mem_dram_wdata = sdata; mem_pc = pc;
        #1;
        if (ale) begin
            n_checks++;
            if ({mem_ready_go, data_sram_req} !== 2'b10) begin
                n_errors++;
                $display("FAIL ale_comb got rg=%b req=%b want rg=1 req=0", mem_ready_go, data_sram_req);
            end
            @(negedge clk);
            n_checks++;
            if ({wb_valid, wb_ref_we, wb_rd, wb_pc, wb_ale, data_sram_req} !==
                {1'b1, 1'b0, rd, pc, 1'b1, 1'b0}) begin
                n_errors++;
                $display("FAIL ale_wb got v=%b we=%b rd=%0d pc=%h ale=%b req=%b want 1 0 %0d %h 1 0",
                         wb_valid, wb_ref_we, wb_rd, wb_pc, wb_ale, data_sram_req, rd, pc);
            end
            if (is_st) begin
                n_checks++;
                if (wb_result !== alu) begin
                    n_errors++;
                    $display("FAIL ale_wb_result got %h want %h", wb_result, alu);
                end
            end
            m_res_known = is_st;
            m_wb_result = alu;
            mem_valid = 0;
            return;
        end
        n_checks++;
        if (mem_ready_go !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_ready got %b want 0", mem_ready_go);
        end
        accepted = 0; responded = 0; req_cyc = 0; wait_left = 0; guard = 0;
        while (!responded && guard < 50) begin
            @(negedge clk);
            guard++;
            data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = $urandom;
            n_checks++;
            if (!accepted) begin
                if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb} !==
                    {1'b1, is_st, 2'(nb / 2), addr, is_st ? 4'(((1 << nb) - 1) << (addr % 4)) : 4'b0}) begin
                    n_errors++;
                    $display("FAIL req_fields got req=%b wr=%b sz=%0d a=%h st=%b want 1 %b %0d %h",
                             data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
                             data_sram_wstrb, is_st, nb / 2, addr);
                end
                if (is_st) begin
                    n_checks++;
                    if (data_sram_wdata !== exp_wdata(nb, sdata)) begin
                        n_errors++;
                        $display("FAIL req_wdata got %h want %h", data_sram_wdata, exp_wdata(nb, sdata));
                    end
                end
            end else if (data_sram_req !== 1'b0) begin
                n_errors++;
                $display("FAIL req_after_accept got req=1 want 0");
            end
            n_checks++;
            if ({mem_ready_go, mem_fwd_ready} !== {1'b0, is_st}) begin
                n_errors++;
                $display("FAIL busy_ready got rg=%b fr=%b want rg=0 fr=%b", mem_ready_go, mem_fwd_ready, is_st);
            end
            if (!accepted) begin
                if (req_cyc == ao_dly) begin
                    data_sram_addr_ok = 1; accepted = 1; wait_left = do_dly;
                end else begin
                    req_cyc++;
                end
            end else begin
                wait_left--;
            end
            if (accepted && wait_left == 0) begin
                data_sram_data_ok = 1; data_sram_rdata = rdata; responded = 1;
            end
        end
        if (!responded) begin
            n_checks++; n_errors++;
            $display("FAIL txn_timeout got no response cycle want completion within 50");
        end
        @(negedge clk);
        data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = $urandom;
        n_checks++;
        if ({data_sram_req, mem_ready_go, mem_fwd_ready, mem_fwd_valid, mem_fwd_data, wb_valid} !==
            {1'b0, 1'b1, 1'b1, (ref_we && rd != 0), exp_res, 1'b0}) begin
            n_errors++;
            $display("FAIL done_state got req=%b rg=%b fr=%b fv=%b fd=%h wbv=%b want 0 1 1 %b %h 0",
                     data_sram_req, mem_ready_go, mem_fwd_ready, mem_fwd_valid, mem_fwd_data,
                     wb_valid, (ref_we && rd != 0), exp_res);
        end
        wb_allow_in = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_ready_go, wb_valid, data_sram_req} !== 3'b100 ||
                (m_res_known && wb_result !== m_wb_result)) begin
                n_errors++;
                $display("FAIL stall_hold got rg=%b wbv=%b req=%b res=%h want 1 0 0 res=%h",
                         mem_ready_go, wb_valid, data_sram_req, wb_result, m_wb_result);
            end
            data_sram_data_ok = 1; data_sram_rdata = $urandom;
            if (s == stall - 1) wb_allow_in = 1;
        end
        @(negedge clk);
        data_sram_data_ok = 0;
        n_checks++;
        if ({wb_valid, wb_ref_we, wb_rd, wb_result, wb_pc, wb_ale, data_sram_req} !==
            {1'b1, ref_we, rd, exp_res, pc, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL access_wb got v=%b we=%b rd=%0d res=%h pc=%h ale=%b req=%b want 1 %b %0d %h %h 0 0",
                     wb_valid, wb_ref_we, wb_rd, wb_result, wb_pc, wb_ale, data_sram_req,
                     ref_we, rd, exp_res, pc);
        end
        m_wb_result = exp_res; m_res_known = 1;
        mem_valid = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; drive_idle();
        m_wb_result = 0; m_res_known = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr,
             data_sram_wdata, wb_valid, wb_ref_we, wb_rd, wb_result, wb_pc, wb_ale, mem_ready_go} !== '0) begin
            n_errors++;
            $display("FAIL reset_state got req=%b addr=%h wbv=%b res=%h pc=%h want all zero",
                     data_sram_req, data_sram_addr, wb_valid, wb_result, wb_pc);
        end
        rst = 0;
    endtask

    task automatic test_alu();
        run_alu(32'h0000_1234, 5'd7, 1'b1, 32'h1C00_0000);
        run_alu(32'hDEAD_BEEF, 5'd0, 1'b1, 32'h1C00_0004);
    endtask

    task automatic test_ld_b();
        run_access(MEM_OP_LD_B, 32'h1000_0003, 32'h5555_0000, 32'h0, 32'h80FF_0011,
                   1, 3, 0, 1'b1, 5'd3, 32'h1C00_0008);
    endtask

    task automatic test_st_h();
        run_access(MEM_OP_ST_H, 32'h2000_0002, 32'h0000_0042, 32'h0000_ABCD, 32'h0,
                   0, 0, 0, 1'b0, 5'd0, 32'h1C00_000C);
    endtask

    task automatic test_ale();
        run_access(MEM_OP_LD_W, 32'h3000_0001, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1'b1, 5'd9, 32'h1C00_0010);
        run_access(MEM_OP_ST_H, 32'h3000_0003, 32'h0000_0077, 32'h1111_2222, 32'h0,
                   0, 0, 0, 1'b1, 5'd4, 32'h1C00_0014);
    endtask

    task automatic test_wb_stall();
        run_access(MEM_OP_LD_HU, 32'h4000_0002, 32'h0, 32'h0, 32'hF00D_8001,
                   0, 1, 3, 1'b1, 5'd12, 32'h1C00_0018);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_idle();
            mem_valid = 1; mem_op = MEM_OP_LD_W; mem_dram_re = 1; mem_res_from_dram = 1;
            mem_ref_we = 1; mem_rd = 5'd2; mem_alu_result = 32'h5000_0000; mem_pc = 32'h1C00_0020;
            @(negedge clk);
            if (k == 1) begin
                data_sram_addr_ok = 1;
                @(negedge clk);
                data_sram_addr_ok = 0;
            end
            #2;
            rst = 1; mem_valid = 0;
            #1;
            n_checks++;
            if ({data_sram_req, data_sram_addr, data_sram_size, wb_valid, mem_ready_go} !== '0) begin
                n_errors++;
                $display("FAIL reset_mid%0d got req=%b addr=%h sz=%0d wbv=%b rg=%b want all zero",
                         k, data_sram_req, data_sram_addr, data_sram_size, wb_valid, mem_ready_go);
            end
            @(negedge clk);
            rst = 0;
            data_sram_data_ok = 1; data_sram_rdata = 32'hBAD0_BAD0;
            @(negedge clk);
            data_sram_data_ok = 0;
            n_checks++;
            if ({data_sram_req, wb_valid, wb_result, mem_ready_go} !== '0) begin
                n_errors++;
                $display("FAIL stray_data_ok%0d got req=%b wbv=%b res=%h rg=%b want all zero",
                         k, data_sram_req, wb_valid, wb_result, mem_ready_go);
            end
            m_wb_result = 0; m_res_known = 1;
        end
        run_access(MEM_OP_LD_H, 32'h5000_0002, 32'h0, 32'h0, 32'h8123_4567,
                   0, 2, 0, 1'b1, 5'd2, 32'h1C00_0024);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int kind, nb;
            logic [31:0] addr;
            kind = $urandom_range(0, 8);
            if (kind == 8) begin
                run_alu($urandom, 5'($urandom), 1'($urandom), $urandom);
            end else begin
                nb   = op_bytes(3'(kind));
                addr = $urandom;
                if ($urandom_range(0, 3) != 0) addr = addr - (addr % nb);
                run_access(3'(kind), addr, $urandom, $urandom, $urandom,
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                           1'($urandom), 5'($urandom), $urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ld_b();
        test_st_h();
        test_ale();
        test_wb_stall();
        test_reset_mid();
        test_random();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got run still active want finished");
        $fatal(1);
    end

endmodule
